// File: rtl/pipe_scroller.sv
// pipe_scroller: scrolls and respawns the Flappy-VGA pipes, scores passes, and registers the in-scope pipe's edges (1-cycle latency).
// No backpressure: Frame_Tick is consumed in its own cycle. Define PIPE_SPEEDUP_EN to raise the scroll step as the score grows.
module pipe_scroller #(
    parameter int         NUM_PIPES    = 2,
    parameter int         PIPE_WIDTH   = 60,
    parameter int         PIPE_SPACING = 320,
    parameter int         GAP_HEIGHT   = 120,
    parameter int         GAP_MIN      = 60,
    parameter int         SCROLL_STEP  = 2,
    parameter int         SCREEN_W     = 640,
    parameter logic [7:0] LFSR_SEED    = 8'hA5
) (
    input  logic       Clk,
    input  logic       reset,
    input  logic       Start,
    input  logic       Q_Initial,
    input  logic       Q_Lose,
    input  logic       Frame_Tick,
    input  logic [9:0] Bird_X_L,
    output logic [9:0] X_Edge_Left,
    output logic [9:0] X_Edge_Right,
    output logic [9:0] Y_Edge_Top,
    output logic [9:0] Y_Edge_Bottom,
    output logic [9:0] Score,
    output logic       Score_Inc,
    output logic       Pipe_Valid
);

    localparam logic [9:0] STEP        = 10'(SCROLL_STEP);
    localparam logic [9:0] RESPAWN_ADD = 10'(NUM_PIPES * PIPE_SPACING);
    localparam logic [9:0] PW          = 10'(PIPE_WIDTH);
    localparam logic [9:0] GH          = 10'(GAP_HEIGHT);
    localparam logic [9:0] GMIN        = 10'(GAP_MIN);
    localparam logic [9:0] X_MAX       = 10'(SCREEN_W - 1);
    localparam logic [9:0] VIS_LIMIT   = 10'(SCREEN_W + PIPE_WIDTH);
    localparam logic [9:0] SCORE_MAX   = 10'd999;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_RUN    = 2'd1,
        S_FROZEN = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic [NUM_PIPES-1:0][9:0] xr_q;
    logic [NUM_PIPES-1:0][9:0] gt_q;
    logic [NUM_PIPES-1:0]      passed_q;
    logic [7:0]                lfsr_q;
    logic [9:0]                score_q;
    logic                      score_inc_q;
    logic [9:0]                x_left_q, x_right_q, y_top_q, y_bot_q;
    logic                      valid_q;

    logic load_init, start_game, scroll_en, score_en, edge_upd, edge_hold;
    logic [9:0] step_eff;

    function automatic logic [9:0] xr_start(input int i);
        return 10'(SCREEN_W + PIPE_WIDTH + i * PIPE_SPACING);
    endfunction

    function automatic logic [9:0] gt_start(input int i);
        return 10'(GAP_MIN + i * 40);
    endfunction

    always_ff @(posedge Clk or negedge reset) begin
        if (!reset) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (Start)     state_d = S_RUN;
            S_RUN:    if (Q_Lose)    state_d = S_FROZEN;
            S_FROZEN: if (Q_Initial) state_d = S_IDLE;
            default:                 state_d = S_IDLE;
        endcase
    end

    // A losing cycle neither scrolls nor scores, even if Frame_Tick coincides.
    always_comb begin
        load_init  = 1'b0;
        start_game = 1'b0;
        scroll_en  = 1'b0;
        score_en   = 1'b0;
        edge_upd   = 1'b0;
        edge_hold  = 1'b0;
        case (state_q)
            S_IDLE: begin
                load_init  = 1'b1;
                start_game = Start;
            end
            S_RUN: begin
                scroll_en = Frame_Tick && !Q_Lose;
                score_en  = !Q_Lose;
                edge_upd  = 1'b1;
            end
            S_FROZEN: edge_hold = 1'b1;
            default: load_init = 1'b1;
        endcase
    end

`ifdef PIPE_SPEEDUP_EN
    localparam logic [9:0] STEP_MAX = 10'(2 * SCROLL_STEP);
    logic [9:0] score_tens;
    always_comb begin
        score_tens = score_q / 10'd10;
        step_eff   = (score_tens >= STEP) ? STEP_MAX : STEP + score_tens;
    end
`else
    assign step_eff = STEP;
`endif

    // Lowest-index eligible pipe scores this cycle; any other waits a cycle.
    logic                 score_hit;
    logic [NUM_PIPES-1:0] score_oh;
    always_comb begin
        score_hit = 1'b0;
        score_oh  = '0;
        for (int i = 0; i < NUM_PIPES; i++) begin
            if (!score_hit && !passed_q[i] && (xr_q[i] < Bird_X_L)) begin
                score_oh[i] = 1'b1;
                score_hit   = 1'b1;
            end
        end
    end

    logic [NUM_PIPES-1:0] respawn;
    always_comb begin
        respawn = '0;
        for (int i = 0; i < NUM_PIPES; i++)
            respawn[i] = scroll_en && (xr_q[i] <= step_eff);
    end

    // Strict '<' keeps the lowest index on equal positions.
    logic       sel_found;
    logic [9:0] sel_xr, sel_gt;
    always_comb begin
        sel_found = 1'b0;
        sel_xr    = '0;
        sel_gt    = '0;
        for (int i = 0; i < NUM_PIPES; i++) begin
            if (!passed_q[i] && (!sel_found || (xr_q[i] < sel_xr))) begin
                sel_found = 1'b1;
                sel_xr    = xr_q[i];
                sel_gt    = gt_q[i];
            end
        end
    end

    always_ff @(posedge Clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_PIPES; i++) begin
                xr_q[i] <= xr_start(i);
                gt_q[i] <= gt_start(i);
            end
            passed_q <= '0;
        end else if (load_init) begin
            for (int i = 0; i < NUM_PIPES; i++) begin
                xr_q[i] <= xr_start(i);
                gt_q[i] <= gt_start(i);
            end
            passed_q <= '0;
        end else begin
            for (int i = 0; i < NUM_PIPES; i++) begin
                if (respawn[i]) begin
                    xr_q[i]     <= xr_q[i] - step_eff + RESPAWN_ADD;
                    gt_q[i]     <= GMIN + {2'b00, lfsr_q};
                    passed_q[i] <= 1'b0;
                end else begin
                    if (scroll_en)               xr_q[i]     <= xr_q[i] - step_eff;
                    if (score_en && score_oh[i]) passed_q[i] <= 1'b1;
                end
            end
        end
    end

    always_ff @(posedge Clk or negedge reset) begin
        if (!reset) lfsr_q <= LFSR_SEED;
        else        lfsr_q <= {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
    end

    always_ff @(posedge Clk or negedge reset) begin
        if (!reset) begin
            score_q     <= '0;
            score_inc_q <= 1'b0;
        end else begin
            score_inc_q <= 1'b0;
            if (start_game) begin
                score_q <= '0;
            end else if (score_en && score_hit) begin
                score_inc_q <= 1'b1;
                if (score_q != SCORE_MAX) score_q <= score_q + 10'd1;
            end
        end
    end

    always_ff @(posedge Clk or negedge reset) begin
        if (!reset) begin
            x_left_q  <= '0;
            x_right_q <= '0;
            y_top_q   <= '0;
            y_bot_q   <= '0;
            valid_q   <= 1'b0;
        end else if (edge_upd && sel_found && (sel_xr < VIS_LIMIT)) begin
            x_right_q <= (sel_xr > X_MAX) ? X_MAX : sel_xr;
            x_left_q  <= (sel_xr >= PW) ? sel_xr - PW : 10'd0;
            y_top_q   <= sel_gt;
            y_bot_q   <= sel_gt + GH;
            valid_q   <= 1'b1;
        end else if (!edge_hold) begin
            x_left_q  <= '0;
            x_right_q <= '0;
            y_top_q   <= '0;
            y_bot_q   <= '0;
            valid_q   <= 1'b0;
        end
    end

    assign X_Edge_Left   = x_left_q;
    assign X_Edge_Right  = x_right_q;
    assign Y_Edge_Top    = y_top_q;
    assign Y_Edge_Bottom = y_bot_q;
    assign Score         = score_q;
    assign Score_Inc     = score_inc_q;
    assign Pipe_Valid    = valid_q;

endmodule

// File: tb/tb_pipe_scroller.sv
// Directed bench for pipe_scroller: default-parameter DUT for scroll/scope/freeze, fast-scrolling DUT for score saturation.
module tb_pipe_scroller;

    logic       clk = 1'b0;
    logic       reset;
    logic       start, q_initial, q_lose, frame_tick;
    logic [9:0] bird_x_l;
    logic [9:0] x_left, x_right, y_top, y_bot, score;
    logic       score_inc, pipe_valid;

    logic       f_start, f_tick;
    logic [9:0] f_bird;
    logic [9:0] f_left, f_right, f_top, f_bot, f_score;
    logic       f_inc, f_valid;

    int         n_checks = 0;
    int         n_pass   = 0;
    logic [7:0] lfsr_m;
    logic [7:0] lfsr_cap;
    int         r0;

    always #5 clk = ~clk;

    pipe_scroller dut (
        .Clk(clk), .reset(reset), .Start(start), .Q_Initial(q_initial), .Q_Lose(q_lose),
        .Frame_Tick(frame_tick), .Bird_X_L(bird_x_l),
        .X_Edge_Left(x_left), .X_Edge_Right(x_right), .Y_Edge_Top(y_top), .Y_Edge_Bottom(y_bot),
        .Score(score), .Score_Inc(score_inc), .Pipe_Valid(pipe_valid)
    );

    pipe_scroller #(.NUM_PIPES(2), .PIPE_SPACING(100), .SCROLL_STEP(50)) dut_fast (
        .Clk(clk), .reset(reset), .Start(f_start), .Q_Initial(1'b0), .Q_Lose(1'b0),
        .Frame_Tick(f_tick), .Bird_X_L(f_bird),
        .X_Edge_Left(f_left), .X_Edge_Right(f_right), .Y_Edge_Top(f_top), .Y_Edge_Bottom(f_bot),
        .Score(f_score), .Score_Inc(f_inc), .Pipe_Valid(f_valid)
    );

    // Reference LFSR: 8-bit Fibonacci, taps 8,6,5,4, seed A5, shifting every clock.
    always @(posedge clk or negedge reset) begin
        if (!reset) lfsr_m <= 8'hA5;
        else        lfsr_m <= {lfsr_m[6:0], lfsr_m[7] ^ lfsr_m[5] ^ lfsr_m[4] ^ lfsr_m[3]};
    end

    task automatic check_eq(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic tick_n(input int n);
        repeat (n) begin
            frame_tick = 1'b1; step(); frame_tick = 1'b0; step(); step();
        end
    endtask

    task automatic f_tick_n(input int n);
        repeat (n) begin
            f_tick = 1'b1; step(); f_tick = 1'b0; step(); step();
        end
    endtask

    // Drops the bird the moment the target is seen, so no second pass can land.
    task automatic f_climb(input int target);
        int c;
        c = 0;
        f_bird = 10'd1023;
        while ((int'(f_score) != target) && (c < 20000)) begin
            f_tick = (c % 2 == 0);
            step();
            c++;
        end
        f_tick = 1'b0;
        f_bird = 10'd0;
        check_eq("f_climb_target", f_score, target);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        reset = 1'b0; start = 1'b0; q_initial = 1'b0; q_lose = 1'b0; frame_tick = 1'b0;
        bird_x_l = 10'd200; f_start = 1'b0; f_tick = 1'b0; f_bird = 10'd0;
        step(); step(); step();
        check_eq("rst_score", score, 0);
        check_eq("rst_valid", pipe_valid, 0);
        check_eq("rst_right", x_right, 0);
        check_eq("rst_bottom", y_bot, 0);
        check_eq("rst_inc", score_inc, 0);
        reset = 1'b1;
        step();

        start = 1'b1; step(); start = 1'b0;
        step();
        check_eq("xr700_not_visible", pipe_valid, 0);
        frame_tick = 1'b1; step(); frame_tick = 1'b0;
        check_eq("edge_latency_valid", pipe_valid, 0);
        step();
        check_eq("first_right", x_right, 639);
        check_eq("first_left", x_left, 638);
        check_eq("first_valid", pipe_valid, 1);
        check_eq("first_top", y_top, 60);
        check_eq("first_bottom", y_bot, 180);

        tick_n(249);
        check_eq("xr200_no_score", score, 0);
        frame_tick = 1'b1; step(); frame_tick = 1'b0;
        check_eq("pass_latency_score", score, 0);
        step();
        check_eq("pass_score", score, 1);
        check_eq("pass_inc", score_inc, 1);
        step();
        check_eq("pass_inc_pulse", score_inc, 0);
        check_eq("scope_pipe1_top", y_top, 100);
        check_eq("scope_pipe1_right", x_right, 518);
        check_eq("scope_pipe1_left", x_left, 458);

        tick_n(98);
        lfsr_cap = lfsr_m;
        tick_n(1);
        check_eq("respawn_no_score", score, 1);
        check_eq("respawn_scope_right", x_right, 320);

        tick_n(60);
        frame_tick = 1'b1; step(); frame_tick = 1'b0;
        step();
        check_eq("pass2_score", score, 2);
        check_eq("pass2_inc", score_inc, 1);
        step();
        check_eq("respawn_right", x_right, 518);
        check_eq("respawn_gap_top", y_top, 60 + int'(lfsr_cap));
        check_eq("respawn_gap_bottom", y_bot, 180 + int'(lfsr_cap));

        q_lose = 1'b1; frame_tick = 1'b1; step(); q_lose = 1'b0; frame_tick = 1'b0;
        step(); step();
        check_eq("lose_tick_left", x_left, 458);
        tick_n(3);
        check_eq("frozen_left", x_left, 458);
        check_eq("frozen_valid", pipe_valid, 1);
        start = 1'b1; step(); start = 1'b0;
        tick_n(1);
        check_eq("frozen_start_ignored", x_left, 458);
        check_eq("frozen_score", score, 2);
        q_initial = 1'b1; step(); q_initial = 1'b0;
        step();
        check_eq("idle_valid", pipe_valid, 0);
        check_eq("idle_left", x_left, 0);
        check_eq("idle_score_hold", score, 2);
        start = 1'b1; step(); start = 1'b0;
        check_eq("restart_score", score, 0);

        tick_n(1);
        check_eq("run2_left", x_left, 638);
        #3 reset = 1'b0;
        #1;
        check_eq("async_rst_valid", pipe_valid, 0);
        check_eq("async_rst_left", x_left, 0);
        check_eq("async_rst_top", y_top, 0);
        step();
        reset = 1'b1;
        step();

        f_start = 1'b1; step(); f_start = 1'b0;
`ifdef PIPE_SPEEDUP_EN
        f_climb(10);
        f_tick_n(8);
        for (int k = 0; k < 4 && f_right <= 10'd51; k++) f_tick_n(1);
        r0 = int'(f_right);
        f_tick_n(1);
        check_eq("speedup_step", r0 - int'(f_right), 51);
`endif
        f_climb(998);
        f_tick_n(8);
        check_eq("f_hold_998", f_score, 998);
        f_bird = 10'd1023;
        step();
        check_eq("sat_first_score", f_score, 999);
        check_eq("sat_first_inc", f_inc, 1);
        step();
        check_eq("sat_second_score", f_score, 999);
        check_eq("sat_second_inc", f_inc, 1);
        step();
        check_eq("sat_done_inc", f_inc, 0);
        check_eq("sat_done_score", f_score, 999);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
